syn_fifo_param: RTL and testbench

Parametrised single-clock FIFO with selectable read mode (registered-output or first-word-fall-through), programmable almost-full/almost-empty thresholds, an exact fill count and synchronous flush. It sits between a producer and a consumer in one clock domain and is the general-purpose buffering block for new designs. Storage is a simple dual-port array; the flag logic is derived from a single registered occupancy counter.

---
 rtl/syn_fifo_pkg.sv | 8 +
 rtl/syn_fifo_param_if.sv | 20 ++
 rtl/syn_fifo_mem.sv | 17 +
 rtl/syn_fifo_param.sv | 90 +++++++++
 tb/tb_syn_fifo_param.sv | 150 +++++++++++++++
 5 files changed

// File: rtl/syn_fifo_pkg.sv
// syn_fifo_pkg: read-mode constants and fill-count width helper for syn_fifo_param
package syn_fifo_pkg;
  localparam int MODE_REG = 0;
  localparam int MODE_FWFT = 1;
  function automatic int cnt_width(input int aw);
    return aw + 1;
  endfunction
endpackage

// File: rtl/syn_fifo_param_if.sv
// syn_fifo_param_if: producer/consumer handshake, data and status bundle of syn_fifo_param
interface syn_fifo_param_if
  import syn_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic clr, wr_cs, wr_en, rd_cs, rd_en;
  logic [DATA_WIDTH-1:0] data_in, data_out;
  logic data_valid, empty, full, almost_empty, almost_full, overflow, underflow;
  logic [cnt_width(ADDR_WIDTH)-1:0] fill_cnt;
  modport master(
    output clr, wr_cs, wr_en, data_in, rd_cs, rd_en,
    input data_out, data_valid, empty, full, almost_empty, almost_full, fill_cnt, overflow, underflow
  );
  modport slave(
    input clr, wr_cs, wr_en, data_in, rd_cs, rd_en,
    output data_out, data_valid, empty, full, almost_empty, almost_full, fill_cnt, overflow, underflow
  );
endinterface

// File: rtl/syn_fifo_mem.sv
// syn_fifo_mem: simple dual-port storage, synchronous write, asynchronous read, no reset
module syn_fifo_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [1 << ADDR_WIDTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/syn_fifo_param.sv
// syn_fifo_param: single-clock FIFO, registered or FWFT read, threshold flags, flush.
// SYN_FIFO_PARAM_ERR_EN enables sticky overflow/underflow flags and their assertions.
module syn_fifo_param
  import syn_fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 4,
  parameter int AFULL_THRESH  = (1 << ADDR_WIDTH) - 2,
  parameter int AEMPTY_THRESH = 2,
  parameter int FWFT          = MODE_REG
) (
  input logic clk,
  input logic rst,
  syn_fifo_param_if.slave bus
);
  localparam int CW = cnt_width(ADDR_WIDTH);
  localparam logic [CW-1:0] DEPTH = CW'(1 << ADDR_WIDTH);
  localparam logic [CW-1:0] AF = CW'(AFULL_THRESH);
  localparam logic [CW-1:0] AE = CW'(AEMPTY_THRESH);
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d, rdata;
  logic dv_q, dv_d, ovf_q, ovf_d, unf_q, unf_d;
  logic wr_req, rd_req, wr_acc, rd_acc, empty, full;
  assign wr_req = bus.wr_cs & bus.wr_en;
  assign rd_req = bus.rd_cs & bus.rd_en;
  assign empty  = cnt_q == '0;
  assign full   = cnt_q == DEPTH;
  // flush wins over both ports, so accepted accesses already exclude clr
  assign wr_acc = wr_req & ~full & ~bus.clr;
  assign rd_acc = rd_req & ~empty & ~bus.clr;
  syn_fifo_mem #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_mem (
    .clk(clk),
    .we(wr_acc),
    .waddr(wr_ptr_q),
    .wdata(bus.data_in),
    .raddr(rd_ptr_q),
    .rdata(rdata)
  );
  always_comb begin
    wr_ptr_d = bus.clr ? '0 : wr_ptr_q + ADDR_WIDTH'(wr_acc);
    rd_ptr_d = bus.clr ? '0 : rd_ptr_q + ADDR_WIDTH'(rd_acc);
    cnt_d    = bus.clr ? '0 : cnt_q + CW'(wr_acc) - CW'(rd_acc);
    dv_d     = rd_acc && FWFT == MODE_REG;
    dout_d   = (rd_acc && FWFT == MODE_REG) ? rdata : dout_q;
`ifdef SYN_FIFO_PARAM_ERR_EN
    ovf_d    = !bus.clr && (ovf_q || (wr_req && full));
    unf_d    = !bus.clr && (unf_q || (rd_req && empty));
`else
    ovf_d    = 1'b0;
    unf_d    = 1'b0;
`endif
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      dout_q   <= '0;
      dv_q     <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      dout_q   <= dout_d;
      dv_q     <= dv_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  assign bus.data_out     = (FWFT == MODE_FWFT) ? rdata : dout_q;
  assign bus.data_valid   = (FWFT == MODE_FWFT) ? ~empty : dv_q;
  assign bus.empty        = empty;
  assign bus.full         = full;
  assign bus.almost_empty = cnt_q <= AE;
  assign bus.almost_full  = cnt_q >= AF;
  assign bus.fill_cnt     = cnt_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = unf_q;
`ifdef SYN_FIFO_PARAM_ERR_EN
`ifndef SYNTHESIS
  always @(posedge clk)
    if (!rst) begin
      a_ovf: assert (!(wr_req && full)) else $warning("syn_fifo_param: write while full");
      a_unf: assert (!(rd_req && empty)) else $warning("syn_fifo_param: read while empty");
    end
`endif
`endif
endmodule

// File: tb/tb_syn_fifo_param.sv
// tb_syn_fifo_param: registered and FWFT instances driven identically, checked against a queue model
module tb_syn_fifo_param;
`ifdef SYN_FIFO_PARAM_ERR_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic rst;
  logic clr, wr_cs, wr_en, rd_cs, rd_en;
  logic [7:0] din;
  int checks = 0;
  int errors = 0;
  logic [7:0] mq[$];
  logic [7:0] sb[$];
  int m_ovf, m_unf, m_dv, m_out;
  always #5 clk = ~clk;
  syn_fifo_param_if #(.DATA_WIDTH(8), .ADDR_WIDTH(2)) i0 ();
  syn_fifo_param_if #(.DATA_WIDTH(8), .ADDR_WIDTH(2)) i1 ();
  assign i0.clr = clr;
  assign i0.wr_cs = wr_cs;
  assign i0.wr_en = wr_en;
  assign i0.data_in = din;
  assign i0.rd_cs = rd_cs;
  assign i0.rd_en = rd_en;
  assign i1.clr = clr;
  assign i1.wr_cs = wr_cs;
  assign i1.wr_en = wr_en;
  assign i1.data_in = din;
  assign i1.rd_cs = rd_cs;
  assign i1.rd_en = rd_en;
  syn_fifo_param #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .AFULL_THRESH(3), .AEMPTY_THRESH(1), .FWFT(0)) d0 (
    .clk(clk), .rst(rst), .bus(i0));
  syn_fifo_param #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .AFULL_THRESH(3), .AEMPTY_THRESH(1), .FWFT(1)) d1 (
    .clk(clk), .rst(rst), .bus(i1));
  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 'h%0h expected 'h%0h at %0t", n, act, exp, $time);
    end
  endtask
  task automatic chk_flags(input string tag, input int cnt, input int e, input int f,
                           input int ae, input int af, input int ov, input int un);
    chk({tag, ".fill_cnt"}, cnt, mq.size());
    chk({tag, ".empty"}, e, mq.size() == 0);
    chk({tag, ".full"}, f, mq.size() == DEPTH);
    chk({tag, ".almost_empty"}, ae, mq.size() <= 1);
    chk({tag, ".almost_full"}, af, mq.size() >= 3);
    chk({tag, ".overflow"}, ov, m_ovf);
    chk({tag, ".underflow"}, un, m_unf);
  endtask
  // reference: a word queue; acceptance follows the occupancy seen before the edge
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete(); sb.delete();
      m_ovf = 0; m_unf = 0; m_dv = 0; m_out = 0;
    end else if (clr) begin
      mq.delete(); sb.delete();
      m_ovf = 0; m_unf = 0; m_dv = 0;
    end else begin
      automatic bit wreq = wr_cs && wr_en;
      automatic bit rreq = rd_cs && rd_en;
      automatic bit wa = wreq && mq.size() < DEPTH;
      automatic bit ra = rreq && mq.size() > 0;
      if (ERR && wreq && mq.size() == DEPTH) m_ovf = 1;
      if (ERR && rreq && mq.size() == 0) m_unf = 1;
      m_dv = ra;
      if (ra) begin
        m_out = mq.pop_front();
        sb.push_back(8'(m_out));
      end
      if (wa) mq.push_back(din);
    end
  end
  always @(negedge clk) begin
    chk_flags("reg", i0.fill_cnt, i0.empty, i0.full, i0.almost_empty, i0.almost_full, i0.overflow, i0.underflow);
    chk_flags("fwft", i1.fill_cnt, i1.empty, i1.full, i1.almost_empty, i1.almost_full, i1.overflow, i1.underflow);
    chk("reg.data_valid", i0.data_valid, m_dv);
    if (i0.data_valid) begin
      if (sb.size() == 0) chk("reg.unexpected_valid", 1, 0);
      else chk("reg.data_out", i0.data_out, sb.pop_front());
    end
    chk("reg.data_out_hold", i0.data_out, m_out);
    chk("fwft.data_valid", i1.data_valid, mq.size() != 0);
    if (mq.size() != 0) chk("fwft.data_out", i1.data_out, mq[0]);
  end
  task automatic step(input bit wc, input bit we, input logic [7:0] d,
                      input bit rc, input bit re, input bit c);
    wr_cs = wc; wr_en = we; din = d; rd_cs = rc; rd_en = re; clr = c;
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input int n);
    repeat (n) step(0, 0, 8'h00, 0, 0, 0);
  endtask
  initial begin
    logic [7:0] pat [5];
    pat = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    rst = 1'b1;
    wr_cs = 0; wr_en = 0; din = 0; rd_cs = 0; rd_en = 0; clr = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    idle(2);
    foreach (pat[i]) step(1, 1, pat[i], 0, 0, 0);
    idle(1);
    repeat (4) step(0, 0, 8'h00, 1, 1, 0);
    idle(2);
    step(0, 0, 8'h00, 1, 1, 0);
    idle(1);
    step(0, 0, 8'h00, 0, 0, 1);
    idle(1);
    step(1, 1, 8'h61, 0, 0, 0);
    step(1, 1, 8'h62, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 1, 8'h63 + 8'(i), 1, 1, 0);
    step(0, 0, 8'h00, 1, 1, 0);
    step(0, 0, 8'h00, 1, 1, 0);
    idle(1);
    step(1, 1, 8'hA5, 0, 0, 0);
    idle(2);
    step(0, 0, 8'h00, 1, 1, 0);
    idle(1);
    for (int i = 0; i < 3; i++) step(1, 1, 8'hC0 + 8'(i), 0, 0, 0);
    step(1, 1, 8'hEE, 0, 0, 1);
    idle(2);
    for (int i = 0; i < 400; i++) begin
      automatic bit hi = ((i / 50) % 2) == 1;
      step($urandom_range(0, 3) != 0, hi ? $urandom_range(0, 3) != 0 : $urandom_range(0, 3) == 0,
           8'($urandom), $urandom_range(0, 3) != 0,
           hi ? $urandom_range(0, 3) == 0 : $urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0);
    end
    idle(1);
    for (int i = 0; i < 3; i++) step(1, 1, 8'h70 + 8'(i), 0, 0, 0);
    wr_cs = 0; wr_en = 0; rd_cs = 1; rd_en = 1;
    @(posedge clk);
    #3 rst = 1'b1;
    rd_cs = 0; rd_en = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    idle(2);
    step(1, 1, 8'h5A, 0, 0, 0);
    idle(1);
    step(0, 0, 8'h00, 1, 1, 0);
    idle(3);
    chk("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
